// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor command controller: opcodes, readback map
// and command-word field positions.
package motor_ctrl_pkg;

    typedef enum logic [7:0] {
        OpSetCh    = 8'h00,
        OpRdAddr   = 8'h01,
        OpSetAll   = 8'h02,
        OpClrFault = 8'h03
    } opcode_e;

    localparam logic [7:0] ADDR_STATUS   = 8'h00;
    localparam logic [7:0] ADDR_ENC_BASE = 8'h01;
    localparam logic [7:0] ADDR_MOT_BASE = 8'h80;

    localparam int unsigned OPC_LSB = 24;
    localparam int unsigned OPC_W   = 8;
    localparam int unsigned CH_LSB  = 11;
    localparam int unsigned CH_W    = 8;
    localparam int unsigned RDA_LSB = 0;
    localparam int unsigned RDA_W   = 8;

    // Motor readback word: target in [26:16], effective duty in [10:0].
    function automatic logic [31:0] pack_mot(input logic [10:0] tgt, input logic [10:0] eff);
        pack_mot = {5'b0, tgt, 5'b0, eff};
    endfunction

endpackage

// File: rtl/pwm_slew_channel.sv
// One PWM channel: commanded target, frame-synchronous slewed effective duty,
// and the registered compare against the shared frame counter.
module pwm_slew_channel #(
    parameter int unsigned PWM_W     = 11,
    parameter int unsigned SLEW_STEP = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_set,
    input  logic [PWM_W-1:0] i_duty,
    input  logic             i_hold,
    input  logic             i_wrap,
    input  logic [PWM_W-1:0] i_frame,
    output logic             o_pwm,
    output logic [PWM_W-1:0] o_target,
    output logic [PWM_W-1:0] o_eff
);

    logic [PWM_W-1:0] r_target;
    logic [PWM_W-1:0] r_eff;
    logic             r_pwm;
    logic             w_up;
    logic [PWM_W-1:0] w_diff;
    logic [PWM_W-1:0] w_step;
    logic [PWM_W-1:0] w_eff_next;

    always_comb begin
        w_up       = r_target > r_eff;
        w_diff     = w_up ? (r_target - r_eff) : (r_eff - r_target);
        w_step     = (32'(w_diff) > SLEW_STEP) ? PWM_W'(SLEW_STEP) : w_diff;
        w_eff_next = r_target;
        // Step never exceeds the remaining distance, so no overshoot/underflow.
        if (SLEW_STEP != 0) begin
            if (w_up) w_eff_next = r_eff + w_step;
            else      w_eff_next = r_eff - w_step;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_target <= '0;
            r_eff    <= '0;
            r_pwm    <= 1'b0;
        end else if (i_hold) begin
            r_target <= '0;
            r_eff    <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_set)  r_target <= i_duty;
            if (i_wrap) r_eff    <= w_eff_next;
            r_pwm <= i_frame < r_eff;
        end
    end

    assign o_pwm    = r_pwm;
    assign o_target = r_target;
    assign o_eff    = r_eff;

endmodule

// File: rtl/motor_cmd_ctrl.sv
// Command-driven multi-channel PWM motor controller with watchdog, error
// counting and a registered readback port.
module motor_cmd_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH     = 6,
    parameter int unsigned PWM_W      = 11,
    parameter int unsigned NUM_ENC    = 1,
    parameter int unsigned SLEW_STEP  = 0,
    parameter int unsigned WDT_CYCLES = 50_000_000
) (
    input  logic                     CLK_50,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [31:0]              cmd_word,
    input  logic [NUM_ENC-1:0][15:0] enc_count,
    input  logic [NUM_ENC-1:0]       enc_dir,
    output logic [NUM_CH-1:0]        pwm_out,
    output logic [31:0]              rsp_word,
    output logic                     fault
);

    localparam int unsigned WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam int unsigned MOT_RD_N = (NUM_CH > 128) ? 128 : NUM_CH;

    logic [PWM_W-1:0] r_frame;
    logic [WDT_W-1:0] r_wdt;
    logic             r_fault;
    logic [7:0]       r_err;
    logic [7:0]       r_rd_addr;
    logic [31:0]      r_last_cmd;
    logic [31:0]      r_rsp;

    opcode_e          w_opcode;
    logic [CH_W-1:0]  w_ch;
    logic [PWM_W-1:0] w_duty;
    logic             w_ch_ok;
    logic             w_set_one, w_set_all, w_clr, w_rd_wr, w_err;
    logic [WDT_W-1:0] w_wdt_d;
    logic             w_trip, w_hold, w_wrap;
    logic [31:0]      w_rsp;
    logic [PWM_W-1:0] w_tgt [NUM_CH];
    logic [PWM_W-1:0] w_eff [NUM_CH];

    assign w_opcode = opcode_e'(cmd_word[OPC_LSB +: OPC_W]);
    assign w_ch     = cmd_word[CH_LSB +: CH_W];
    assign w_duty   = cmd_word[PWM_W-1:0];
    assign w_ch_ok  = {24'b0, w_ch} < NUM_CH;
    assign w_wrap   = r_frame == '1;

    always_comb begin
        w_set_one = 1'b0;
        w_set_all = 1'b0;
        w_clr     = 1'b0;
        w_rd_wr   = 1'b0;
        w_err     = 1'b0;
        // Set commands are silently dropped while faulted, not counted as errors.
        if (cmd_valid) begin
            case (w_opcode)
                OpSetCh: begin
                    if (!r_fault) begin
                        if (w_ch_ok) w_set_one = 1'b1;
                        else         w_err     = 1'b1;
                    end
                end
                OpRdAddr:   w_rd_wr   = 1'b1;
                OpSetAll:   w_set_all = !r_fault;
                OpClrFault: w_clr     = 1'b1;
                default:    w_err     = 1'b1;
            endcase
        end
    end

    // Saturating watchdog; any command restarts it, so a coincident command wins over a trip.
    always_comb begin
        w_wdt_d = r_wdt;
        if (cmd_valid)                               w_wdt_d = '0;
        else if (r_wdt != WDT_W'(WDT_CYCLES))        w_wdt_d = r_wdt + WDT_W'(1);
        w_trip = !r_fault && (w_wdt_d == WDT_W'(WDT_CYCLES));
        w_hold = r_fault || w_trip;
    end

    always_comb begin
        w_rsp = r_last_cmd;
        if (r_rd_addr == ADDR_STATUS) w_rsp = {r_err, 23'b0, r_fault};
        for (int unsigned e = 0; e < NUM_ENC; e++) begin
            if (r_rd_addr == ADDR_ENC_BASE + 8'(e)) w_rsp = {15'b0, enc_dir[e], enc_count[e]};
        end
        for (int unsigned m = 0; m < MOT_RD_N; m++) begin
            if (r_rd_addr == ADDR_MOT_BASE + 8'(m)) w_rsp = pack_mot(11'(w_tgt[m]), 11'(w_eff[m]));
        end
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_frame    <= '0;
            r_wdt      <= '0;
            r_fault    <= 1'b0;
            r_err      <= '0;
            r_rd_addr  <= '0;
            r_last_cmd <= '0;
            r_rsp      <= '0;
        end else begin
            r_frame <= r_frame + PWM_W'(1);
            r_wdt   <= w_wdt_d;
            if (w_clr)       r_fault <= 1'b0;
            else if (w_trip) r_fault <= 1'b1;
            if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (w_rd_wr)   r_rd_addr  <= cmd_word[RDA_LSB +: RDA_W];
            if (cmd_valid) r_last_cmd <= cmd_word;
            r_rsp <= w_rsp;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_slew_channel #(
            .PWM_W    (PWM_W),
            .SLEW_STEP(SLEW_STEP)
        ) u_ch (
            .i_clk   (CLK_50),
            .i_reset (reset),
            .i_set   (w_set_all || (w_set_one && (w_ch == 8'(i)))),
            .i_duty  (w_duty),
            .i_hold  (w_hold),
            .i_wrap  (w_wrap),
            .i_frame (r_frame),
            .o_pwm   (pwm_out[i]),
            .o_target(w_tgt[i]),
            .o_eff   (w_eff[i])
        );
    end

    assign rsp_word = r_rsp;
    assign fault    = r_fault;

endmodule

// File: tb/tb_motor_cmd_ctrl.sv
// Scoreboard bench for motor_cmd_ctrl: three instances (immediate duty, slewed duty,
// short watchdog) driven by directed commands; a monitor checks queued expectations.
module tb_motor_cmd_ctrl;

    localparam int S_RSP_A   = 0;
    localparam int S_PWM_A   = 1;
    localparam int S_FAULT_A = 2;
    localparam int S_RSP_B   = 3;
    localparam int S_PWM_C   = 4;
    localparam int S_FAULT_C = 5;
    localparam int S_RSP_C   = 6;
    localparam int S_MEAS    = 7;

    typedef struct {
        string       name;
        int unsigned due;
        int          sel;
        logic [31:0] exp;
        logic [31:0] meas;
    } exp_t;

    logic clk;
    int unsigned cyc;
    int unsigned n_tests;
    int unsigned n_fail;
    exp_t sb_q[$];

    logic rst_a, rst_b, rst_c;
    logic cv_a, cv_b, cv_c;
    logic [31:0] cw_a, cw_b, cw_c;
    logic [0:0][15:0] enc_a, enc_b, enc_c;
    logic [0:0] dir_a, dir_b, dir_c;
    logic [5:0] pwm_a, pwm_b, pwm_c;
    logic [31:0] rsp_a, rsp_b, rsp_c;
    logic fault_a, fault_b, fault_c;

    motor_cmd_ctrl #(.NUM_CH(6), .PWM_W(11), .NUM_ENC(1), .SLEW_STEP(0)) u_a (
        .CLK_50(clk), .reset(rst_a), .cmd_valid(cv_a), .cmd_word(cw_a), .enc_count(enc_a),
        .enc_dir(dir_a), .pwm_out(pwm_a), .rsp_word(rsp_a), .fault(fault_a));

    motor_cmd_ctrl #(.NUM_CH(6), .PWM_W(11), .NUM_ENC(1), .SLEW_STEP(100)) u_b (
        .CLK_50(clk), .reset(rst_b), .cmd_valid(cv_b), .cmd_word(cw_b), .enc_count(enc_b),
        .enc_dir(dir_b), .pwm_out(pwm_b), .rsp_word(rsp_b), .fault(fault_b));

    motor_cmd_ctrl #(.NUM_CH(6), .PWM_W(11), .NUM_ENC(1), .SLEW_STEP(0), .WDT_CYCLES(1000)) u_c (
        .CLK_50(clk), .reset(rst_c), .cmd_valid(cv_c), .cmd_word(cw_c), .enc_count(enc_c),
        .enc_dir(dir_c), .pwm_out(pwm_c), .rsp_word(rsp_c), .fault(fault_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_RSP_A:   obs = rsp_a;
            S_PWM_A:   obs = {26'b0, pwm_a};
            S_FAULT_A: obs = {31'b0, fault_a};
            S_RSP_B:   obs = rsp_b;
            S_PWM_C:   obs = {26'b0, pwm_c};
            S_FAULT_C: obs = {31'b0, fault_c};
            S_RSP_C:   obs = rsp_c;
            default:   obs = '0;
        endcase
    endfunction

    function automatic void expect_at(input string name, input int unsigned due, input int sel,
                                      input logic [31:0] exp, input logic [31:0] meas);
        exp_t it;
        it.name = name; it.due = due; it.sel = sel; it.exp = exp; it.meas = meas;
        sb_q.push_back(it);
    endfunction

    // Monitor: compares every queued expectation on the cycle it falls due.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cyc) begin
                act = (sb_q[i].sel == S_MEAS) ? sb_q[i].meas : obs(sb_q[i].sel);
                n_tests++;
                if (sb_q[i].due < cyc || act !== sb_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                             sb_q[i].name, act, sb_q[i].exp, cyc, sb_q[i].due);
                end
                sb_q.delete(i);
            end
        end
    end

    // Must be called at a negedge; returns the cycle count at the drive point.
    task automatic send(input int inst, input logic [31:0] w, output int unsigned c);
        c = cyc;
        case (inst)
            0: begin cv_a = 1'b1; cw_a = w; end
            1: begin cv_b = 1'b1; cw_b = w; end
            default: begin cv_c = 1'b1; cw_c = w; end
        endcase
        @(negedge clk);
        case (inst)
            0: cv_a = 1'b0;
            1: cv_b = 1'b0;
            default: cv_c = 1'b0;
        endcase
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic count_a(input int ch, input int n, output int unsigned hi,
                           output int unsigned oth);
        hi = 0; oth = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_a[ch]) hi++;
            if ((pwm_a & ~(6'b1 << ch)) != 6'b0) oth++;
        end
    endtask

    task automatic wait_b_change(input logic [10:0] prev, output logic [10:0] val,
                                 output int unsigned at);
        for (int i = 0; i < 2300; i++) begin
            @(negedge clk);
            if (rsp_b[10:0] != prev) break;
        end
        val = rsp_b[10:0];
        at  = cyc;
    endtask

    initial begin
        #400000;
        $display("FAIL global timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned r0;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_a = 1; rst_b = 1; rst_c = 1;
        cv_a = 0; cv_b = 0; cv_c = 0;
        cw_a = '0; cw_b = '0; cw_c = '0;
        enc_a[0] = 16'h1234; dir_a = 1'b1;
        enc_b[0] = 16'h0; dir_b = 1'b0;
        enc_c[0] = 16'h0; dir_c = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 0; rst_b = 0; rst_c = 0;
        r0 = cyc;

        fork
            begin : br_a
                int unsigned c, hi, oth;
                logic found;
                expect_at("a reset rsp", cyc + 1, S_RSP_A, 32'h0, 0);
                expect_at("a reset pwm", cyc + 1, S_PWM_A, 32'h0, 0);
                expect_at("a reset fault", cyc + 1, S_FAULT_A, 32'h0, 0);
                send(0, 32'h000011F4, c);                         // ch2 <= 500
                repeat (2100) @(negedge clk);
                count_a(2, 2048, hi, oth);
                expect_at("a ch2 duty 500 highs", cyc + 1, S_MEAS, 500, hi);
                expect_at("a other ch idle", cyc + 1, S_MEAS, 0, oth);
                n_tests++;
                if (hi !== 500) begin
                    n_fail++;
                    $display("FAIL a direct ch2 highs: got %0d expected 500", hi);
                end
                n_tests++;
                if (oth !== 0) begin
                    n_fail++;
                    $display("FAIL a direct other idle: got %0d expected 0", oth);
                end
                send(0, 32'h01000082, c);
                expect_at("a rb mot2", c + 2, S_RSP_A, 32'h01F401F4, 0);
                send(0, 32'h000007FF, c);                         // ch0 <= 2047
                repeat (2100) @(negedge clk);
                count_a(0, 2048, hi, oth);
                expect_at("a ch0 duty 2047 highs", cyc + 1, S_MEAS, 2047, hi);
                expect_at("a ch2 highs alongside", cyc + 1, S_MEAS, 500, oth);
                n_tests++;
                if (hi !== 2047) begin
                    n_fail++;
                    $display("FAIL a direct ch0 highs: got %0d expected 2047", hi);
                end
                n_tests++;
                if (oth !== 500) begin
                    n_fail++;
                    $display("FAIL a direct ch2 alongside: got %0d expected 500", oth);
                end
                send(0, 32'h01000001, c);
                expect_at("a rb enc0", c + 2, S_RSP_A, 32'h00011234, 0);
                send(0, 32'h07000000, c);
                send(0, 32'h00003000, c);                         // ch6 out of range
                send(0, 32'h01000000, c);
                expect_at("a err_cnt 2", c + 2, S_RSP_A, 32'h02000000, 0);
                repeat (300) send(0, 32'hFF000000, c);
                expect_at("a err_cnt saturate", c + 2, S_RSP_A, 32'hFF000000, 0);
                send(0, 32'h01000040, c);
                expect_at("a rb unmapped", c + 2, S_RSP_A, 32'h01000040, 0);
                send(0, 32'h00000BE8, c);                         // ch1 <= 1000
                found = 1'b0;
                for (int i = 0; i < 4300 && !found; i++) begin
                    @(negedge clk);
                    found = pwm_a[1];
                end
                expect_at("a ch1 active pre-reset", cyc + 1, S_MEAS, 1, {31'b0, found});
                c = cyc;
                rst_a = 1'b1; cv_a = 1'b1; cw_a = 32'h00001FD0;   // ch3 set under reset
                expect_at("a reset pwm low", c + 1, S_PWM_A, 32'h0, 0);
                expect_at("a reset rsp zero", c + 1, S_RSP_A, 32'h0, 0);
                @(negedge clk);
                rst_a = 1'b0; cv_a = 1'b0;
                send(0, 32'h01000081, c);
                expect_at("a rb mot1 after reset", c + 2, S_RSP_A, 32'h0, 0);
                send(0, 32'h01000083, c);
                expect_at("a reset beats cmd", c + 2, S_RSP_A, 32'h0, 0);
                send(0, 32'h01000000, c);
                expect_at("a status after reset", c + 2, S_RSP_A, 32'h0, 0);
            end
            begin : br_b
                int unsigned c, at, last_at;
                logic [10:0] prev, val;
                int unsigned seq [7];
                seq = '{100, 200, 300, 350, 250, 150, 120};
                send(1, 32'h01000080, c);
                send(1, 32'h0000015E, c);                         // ch0 <= 350
                prev = '0; last_at = 0;
                for (int k = 0; k < 7; k++) begin
                    if (k == 4) begin
                        repeat (4200) @(negedge clk);
                        expect_at("b stable 350", cyc + 1, S_RSP_B, 32'h015E015E, 0);
                        send(1, 32'h02000078, c);                 // all <= 120
                    end
                    wait_b_change(prev, val, at);
                    expect_at($sformatf("b eff step %0d", k), cyc + 1, S_MEAS, seq[k],
                              {21'b0, val});
                    if (k != 0 && k != 4)
                        expect_at($sformatf("b step spacing %0d", k), cyc + 1, S_MEAS, 2048,
                                  at - last_at);
                    last_at = at;
                    prev = val;
                end
                send(1, 32'h01000085, c);
                expect_at("b rb mot5", c + 2, S_RSP_B, 32'h00780078, 0);
            end
            begin : br_c
                int unsigned c, e, hi;
                wait_until(r0 + 1);
                send(2, 32'h000007FF, c);
                wait_until(r0 + 800);
                send(2, 32'h01000000, c);
                wait_until(r0 + 1600);
                send(2, 32'h01000000, c);
                wait_until(r0 + 2099);
                send(2, 32'h000007FF, c);
                e = c + 1;
                expect_at("c no fault before trip", e + 999, S_FAULT_C, 32'h0, 0);
                expect_at("c pwm high before trip", e + 999, S_PWM_C, 32'h1, 0);
                expect_at("c fault at trip", e + 1000, S_FAULT_C, 32'h1, 0);
                expect_at("c pwm low at trip", e + 1000, S_PWM_C, 32'h0, 0);
                hi = 0;
                repeat (999) begin
                    @(negedge clk);
                    if (pwm_c[0]) hi++;
                end
                expect_at("c highs in idle window", cyc + 1, S_MEAS, 999, hi);
                @(negedge clk); @(negedge clk);
                send(2, 32'h000003E8, c);                         // ignored while faulted
                send(2, 32'h01000080, c);
                expect_at("c set ignored in fault", c + 2, S_RSP_C, 32'h0, 0);
                send(2, 32'h01000000, c);
                expect_at("c status faulted", c + 2, S_RSP_C, 32'h00000001, 0);
                send(2, 32'h03000000, c);
                expect_at("c fault cleared", c + 1, S_FAULT_C, 32'h0, 0);
                expect_at("c status cleared", c + 2, S_RSP_C, 32'h0, 0);
            end
        join

        for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
        while (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got nothing expected check at cycle %0d",
                     sb_q[0].name, sb_q[0].due);
            void'(sb_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
